// File: rtl/regfile_sb.sv
// ---------------------------------------------------------------------------
// regfile_sb
//
// Register file with two combinational read ports and one synchronous write
// port. It also keeps a per-register "pending" scoreboard, so decode can see
// read-after-write hazards directly from the register file.
//
// Parameters
//   DATA_W    register width in bits
//   ADDR_W    register index width (NUM_REGS = 2**ADDR_W)
//   ZERO_REG  1 = register 0 reads as zero and ignores writes and issues
//   BYPASS    1 = same-cycle write data is forwarded to the read ports and
//               the Busy flag of the written register is masked
//
// Ports
//   clk           clock; all state changes on the rising edge
//   rst           synchronous, active-high reset
//   SrcReg1/2     read port indices
//   SrcData1/2    read port data (combinational)
//   Busy1/2       read index has an outstanding producer (combinational)
//   DstReg        writeback index
//   WriteReg      writeback enable; also retires the pending bit of DstReg
//   DstData       writeback data
//   IssueValid    an instruction that will write IssueReg has issued
//   IssueReg      destination of the issued instruction
//   PendingCount  number of pending registers (registered)
// ---------------------------------------------------------------------------
module regfile_sb #(
   parameter int DATA_W   = 16,
   parameter int ADDR_W   = 4,
   parameter bit ZERO_REG = 1'b0,
   parameter bit BYPASS   = 1'b1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] SrcReg1,
   input  logic [ADDR_W-1:0] SrcReg2,
   input  logic [ADDR_W-1:0] DstReg,
   input  logic              WriteReg,
   input  logic [DATA_W-1:0] DstData,
   input  logic              IssueValid,
   input  logic [ADDR_W-1:0] IssueReg,
   output logic [DATA_W-1:0] SrcData1,
   output logic [DATA_W-1:0] SrcData2,
   output logic              Busy1,
   output logic              Busy2,
   output logic [ADDR_W:0]   PendingCount
);

   localparam int NUM_REGS = 2 ** ADDR_W;
   localparam int CNT_W    = ADDR_W + 1;

   // Largest reachable popcount: register 0 can never be pending when it is
   // hard-wired to zero.
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(NUM_REGS - (ZERO_REG ? 1 : 0));

   logic [DATA_W-1:0]   regs [NUM_REGS];
   logic [NUM_REGS-1:0] pend;
   logic [NUM_REGS-1:0] pend_nxt;
   logic [CNT_W-1:0]    cnt;
   logic [CNT_W-1:0]    cnt_nxt;

   logic wr_live;    // writeback present and not swallowed by reset
   logic wr_ok;      // writeback that actually updates storage
   logic iss_ok;     // issue that actually sets a pending bit
   logic same_idx;   // issue and writeback hit the same register
   logic cnt_inc;
   logic cnt_dec;
   logic byp1;
   logic byp2;

   // True when idx addresses the hard-wired zero register.
   function automatic logic is_zero_idx(input logic [ADDR_W-1:0] idx);
      return ZERO_REG && (idx == '0);
   endfunction

   // Clamped counter update; the clamps only guard against an impossible
   // combination and keep the counter from ever wrapping.
   function automatic logic [CNT_W-1:0] cnt_step(input logic [CNT_W-1:0] cur,
                                                 input logic             inc,
                                                 input logic             dec);
      logic [CNT_W-1:0] res;
      res = cur;
      if (inc && !dec && (cur != CNT_MAX)) begin
         res = cur + CNT_W'(1);
      end else if (dec && !inc && (cur != '0)) begin
         res = cur - CNT_W'(1);
      end
      return res;
   endfunction

   // ------------------------------------------------------------------------
   // Event qualification
   // ------------------------------------------------------------------------
   always_comb begin
      wr_live  = WriteReg && !rst;
      wr_ok    = wr_live && !is_zero_idx(DstReg);
      iss_ok   = IssueValid && !rst && !is_zero_idx(IssueReg);
      same_idx = iss_ok && (IssueReg == DstReg);

      // A re-issue of a pending register and a retire of a clear register
      // both leave the population unchanged.
      cnt_inc  = iss_ok && !pend[IssueReg];
      cnt_dec  = wr_live && pend[DstReg] && !same_idx;
      cnt_nxt  = cnt_step(cnt, cnt_inc, cnt_dec);
   end

   // Clear first, then set: a new producer to the same register wins over
   // the retiring one.
   always_comb begin
      pend_nxt = pend;
      if (wr_live) begin
         pend_nxt[DstReg] = 1'b0;
      end
      if (iss_ok) begin
         pend_nxt[IssueReg] = 1'b1;
      end
   end

   // ------------------------------------------------------------------------
   // State registers
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            regs[i] <= '0;
         end
         pend <= '0;
         cnt  <= '0;
      end else begin
         if (wr_ok) begin
            regs[DstReg] <= DstData;
         end
         pend <= pend_nxt;
         cnt  <= cnt_nxt;
      end
   end

   // ------------------------------------------------------------------------
   // Read ports
   // ------------------------------------------------------------------------
   // wr_ok already excludes reset and writes to the zero register, so bypass
   // and Busy masking switch off automatically in those cases.
   always_comb begin
      byp1 = BYPASS && wr_ok && (DstReg == SrcReg1);
      byp2 = BYPASS && wr_ok && (DstReg == SrcReg2);

      if (is_zero_idx(SrcReg1)) begin
         SrcData1 = '0;
      end else if (byp1) begin
         SrcData1 = DstData;
      end else begin
         SrcData1 = regs[SrcReg1];
      end

      if (is_zero_idx(SrcReg2)) begin
         SrcData2 = '0;
      end else if (byp2) begin
         SrcData2 = DstData;
      end else begin
         SrcData2 = regs[SrcReg2];
      end

      Busy1 = pend[SrcReg1] && !byp1;
      Busy2 = pend[SrcReg2] && !byp2;
   end

   assign PendingCount = cnt;

endmodule
